// File: rtl/synth_pkg.sv
// Shared synth definitions: voice-RAM write kinds, allocator defaults and
// FSM states, candidate priority classes, and ADSR states used by the voice-RAM writer.
package synth_pkg;

    localparam int NUM_VOICES_DEF = 32;

    localparam logic [1:0] WR_START   = 2'd0;
    localparam logic [1:0] WR_RELEASE = 2'd1;
    localparam logic [1:0] WR_STEAL   = 2'd2;
    localparam logic [1:0] WR_RETRIG  = 2'd3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_ISSUE = 2'd2;

    // Higher class wins; a note-off candidate always uses CLS_MATCH.
    localparam logic [1:0] CLS_HELD     = 2'd0;
    localparam logic [1:0] CLS_RELEASED = 2'd1;
    localparam logic [1:0] CLS_FREE     = 2'd2;
    localparam logic [1:0] CLS_MATCH    = 2'd3;

    localparam logic [2:0] ADSR_BLANK   = 3'd0;
    localparam logic [2:0] ADSR_ATTACK  = 3'd1;
    localparam logic [2:0] ADSR_DECAY   = 3'd2;
    localparam logic [2:0] ADSR_SUSTAIN = 3'd3;
    localparam logic [2:0] ADSR_RELEASE = 3'd4;

    function automatic logic [1:0] kind_of_class(input logic is_on, input logic [1:0] cls);
        logic [1:0] kind;
        if (!is_on) begin
            kind = WR_RELEASE;
        end else begin
            case (cls)
                CLS_MATCH: kind = WR_RETRIG;
                CLS_FREE:  kind = WR_START;
                default:   kind = WR_STEAL;
            endcase
        end
        return kind;
    endfunction

endpackage

// File: rtl/voice_candidate_sel.sv
// Compares the voice under scan against the running best candidate
// (priority class, then age for steal classes, then lower index).
module voice_candidate_sel
    import synth_pkg::*;
#(
    parameter int VIDX_W  = 5,
    parameter int STAMP_W = 16
) (
    input  logic               is_on,
    input  logic [6:0]         cmd_note,
    input  logic [3:0]         cmd_channel,
    input  logic [STAMP_W-1:0] now,
    input  logic [VIDX_W-1:0]  cur_idx,
    input  logic               e_used,
    input  logic               e_released,
    input  logic [6:0]         e_note,
    input  logic [3:0]         e_channel,
    input  logic [STAMP_W-1:0] e_stamp,
    input  logic               best_valid,
    input  logic [1:0]         best_class,
    input  logic [STAMP_W-1:0] best_age,
    input  logic [VIDX_W-1:0]  best_idx,
    output logic               take,
    output logic [1:0]         cand_class,
    output logic [STAMP_W-1:0] cand_age
);

    logic match;
    logic eligible;

    // Classify the current entry and decide whether it beats the running best
    always_comb begin
        match    = (e_note == cmd_note) && (e_channel == cmd_channel);
        cand_age = now - e_stamp;
        if (is_on) begin
            eligible = 1'b1;
            if (e_used && !e_released && match) begin
                cand_class = CLS_MATCH;
            end else if (!e_used) begin
                cand_class = CLS_FREE;
            end else if (e_released) begin
                cand_class = CLS_RELEASED;
            end else begin
                cand_class = CLS_HELD;
            end
        end else begin
            eligible   = e_used && !e_released && match;
            cand_class = CLS_MATCH;
        end

        // Retrigger/free/release picks want the lowest index; steals want the oldest.
        if (!eligible) begin
            take = 1'b0;
        end else if (!best_valid) begin
            take = 1'b1;
        end else if (cand_class != best_class) begin
            take = cand_class > best_class;
        end else if (cand_class[1] || !is_on) begin
            take = cur_idx < best_idx;
        end else if (cand_age != best_age) begin
            take = cand_age > best_age;
        end else begin
            take = cur_idx < best_idx;
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Voice allocation scheduler: shadows voice occupancy in registers, scans one
// voice per cycle to pick a slot, then issues one voice-RAM write command.
module voice_allocator
    import synth_pkg::*;
#(
    parameter int NUM_VOICES = NUM_VOICES_DEF,
    parameter int VIDX_W     = 5,
    parameter int STAMP_W    = 16
) (
    input  logic              clk32,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_on,
    input  logic [6:0]        cmd_note,
    input  logic [3:0]        cmd_channel,
    input  logic [6:0]        cmd_velocity,
    input  logic              free_valid,
    input  logic [VIDX_W-1:0] free_idx,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [VIDX_W-1:0] wr_idx,
    output logic [1:0]        wr_kind,
    output logic [6:0]        wr_note,
    output logic [3:0]        wr_channel,
    output logic [6:0]        wr_velocity,
    output logic [VIDX_W:0]   active_count,
    output logic              busy,
    output logic              miss
);

    localparam logic [VIDX_W-1:0] LAST_IDX = VIDX_W'(NUM_VOICES - 1);

    logic [1:0]         state_q, state_d;
    logic [VIDX_W-1:0]  scan_idx_q, scan_idx_d;
    logic               c_on_q, c_on_d;
    logic [6:0]         c_note_q, c_note_d;
    logic [3:0]         c_chan_q, c_chan_d;
    logic [6:0]         c_vel_q, c_vel_d;
    logic               best_valid_q, best_valid_d;
    logic [1:0]         best_class_q, best_class_d;
    logic [STAMP_W-1:0] best_age_q, best_age_d;
    logic [VIDX_W-1:0]  best_idx_q, best_idx_d;
    logic [STAMP_W-1:0] now_q, now_d;
    logic               wr_valid_q, wr_valid_d;
    logic [VIDX_W-1:0]  wr_idx_q, wr_idx_d;
    logic [1:0]         wr_kind_q, wr_kind_d;
    logic [6:0]         wr_note_q, wr_note_d;
    logic [3:0]         wr_chan_q, wr_chan_d;
    logic [6:0]         wr_vel_q, wr_vel_d;
    logic               miss_q, miss_d;
    logic [VIDX_W:0]    active_count_q, active_count_d;

    logic [NUM_VOICES-1:0] used_q, used_d, rel_q, rel_d;
    logic [6:0]            vnote_q  [NUM_VOICES];
    logic [6:0]            vnote_d  [NUM_VOICES];
    logic [3:0]            vchan_q  [NUM_VOICES];
    logic [3:0]            vchan_d  [NUM_VOICES];
    logic [STAMP_W-1:0]    vstamp_q [NUM_VOICES];
    logic [STAMP_W-1:0]    vstamp_d [NUM_VOICES];

    logic               wr_hs;
    logic               sel_take;
    logic [1:0]         sel_class;
    logic [STAMP_W-1:0] sel_age;

    assign wr_hs        = wr_valid_q & wr_ready;
    assign cmd_ready    = (state_q == ST_IDLE) & ~rst;
    assign busy         = (state_q != ST_IDLE);
    assign wr_valid     = wr_valid_q;
    assign wr_idx       = wr_idx_q;
    assign wr_kind      = wr_kind_q;
    assign wr_note      = wr_note_q;
    assign wr_channel   = wr_chan_q;
    assign wr_velocity  = wr_vel_q;
    assign miss         = miss_q;
    assign active_count = active_count_q;

    voice_candidate_sel #(
        .VIDX_W  (VIDX_W),
        .STAMP_W (STAMP_W)
    ) u_sel (
        .is_on       (c_on_q),
        .cmd_note    (c_note_q),
        .cmd_channel (c_chan_q),
        .now         (now_q),
        .cur_idx     (scan_idx_q),
        .e_used      (used_q[scan_idx_q]),
        .e_released  (rel_q[scan_idx_q]),
        .e_note      (vnote_q[scan_idx_q]),
        .e_channel   (vchan_q[scan_idx_q]),
        .e_stamp     (vstamp_q[scan_idx_q]),
        .best_valid  (best_valid_q),
        .best_class  (best_class_q),
        .best_age    (best_age_q),
        .best_idx    (best_idx_q),
        .take        (sel_take),
        .cand_class  (sel_class),
        .cand_age    (sel_age)
    );

    // Command FSM: latch, scan for the best slot, then hold the write until accepted
    always_comb begin
        state_d      = state_q;
        scan_idx_d   = scan_idx_q;
        c_on_d       = c_on_q;
        c_note_d     = c_note_q;
        c_chan_d     = c_chan_q;
        c_vel_d      = c_vel_q;
        best_valid_d = best_valid_q;
        best_class_d = best_class_q;
        best_age_d   = best_age_q;
        best_idx_d   = best_idx_q;
        now_d        = now_q;
        wr_valid_d   = wr_valid_q;
        wr_idx_d     = wr_idx_q;
        wr_kind_d    = wr_kind_q;
        wr_note_d    = wr_note_q;
        wr_chan_d    = wr_chan_q;
        wr_vel_d     = wr_vel_q;
        miss_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    c_on_d       = cmd_on;
                    c_note_d     = cmd_note;
                    c_chan_d     = cmd_channel;
                    c_vel_d      = cmd_velocity;
                    scan_idx_d   = '0;
                    best_valid_d = 1'b0;
                    best_class_d = CLS_HELD;
                    best_age_d   = '0;
                    best_idx_d   = '0;
                    state_d      = ST_SCAN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (sel_take) begin
                    best_valid_d = 1'b1;
                    best_class_d = sel_class;
                    best_age_d   = sel_age;
                    best_idx_d   = scan_idx_q;
                end else begin
                    best_valid_d = best_valid_q;
                end
                if (scan_idx_q == LAST_IDX) begin
                    state_d    = ST_ISSUE;
                    wr_valid_d = best_valid_d;
                    miss_d     = ~best_valid_d;
                    if (best_valid_d) begin
                        wr_idx_d  = best_idx_d;
                        wr_kind_d = kind_of_class(c_on_q, best_class_d);
                        wr_note_d = c_note_q;
                        wr_chan_d = c_chan_q;
                        wr_vel_d  = c_vel_q;
                    end else begin
                        wr_idx_d = wr_idx_q;
                    end
                end else begin
                    scan_idx_d = scan_idx_q + VIDX_W'(1);
                end
            end
            ST_ISSUE: begin
                if (!wr_valid_q) begin
                    state_d = ST_IDLE;
                end else if (wr_ready) begin
                    wr_valid_d = 1'b0;
                    state_d    = ST_IDLE;
                    now_d      = c_on_q ? (now_q + STAMP_W'(1)) : now_q;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Shadow table next state: a note-on handshake beats a free, a free beats a release
    always_comb begin
        used_d   = used_q;
        rel_d    = rel_q;
        vnote_d  = vnote_q;
        vchan_d  = vchan_q;
        vstamp_d = vstamp_q;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (wr_hs && (wr_idx_q == VIDX_W'(i)) && (wr_kind_q != WR_RELEASE)) begin
                used_d[i]   = 1'b1;
                rel_d[i]    = 1'b0;
                vnote_d[i]  = wr_note_q;
                vchan_d[i]  = wr_chan_q;
                vstamp_d[i] = now_q;
            end else if (free_valid && (free_idx == VIDX_W'(i))) begin
                used_d[i] = 1'b0;
                rel_d[i]  = 1'b0;
            end else if (wr_hs && (wr_idx_q == VIDX_W'(i))) begin
                rel_d[i] = used_q[i];
            end else begin
                used_d[i] = used_q[i];
            end
        end
    end

    // Population count of occupied voices, registered below
    always_comb begin
        active_count_d = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            active_count_d = active_count_d + (VIDX_W + 1)'(used_q[i]);
        end
    end

    // Control and output registers
    always_ff @(posedge clk32 or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            scan_idx_q     <= '0;
            c_on_q         <= 1'b0;
            c_note_q       <= '0;
            c_chan_q       <= '0;
            c_vel_q        <= '0;
            best_valid_q   <= 1'b0;
            best_class_q   <= CLS_HELD;
            best_age_q     <= '0;
            best_idx_q     <= '0;
            now_q          <= '0;
            wr_valid_q     <= 1'b0;
            wr_idx_q       <= '0;
            wr_kind_q      <= WR_START;
            wr_note_q      <= '0;
            wr_chan_q      <= '0;
            wr_vel_q       <= '0;
            miss_q         <= 1'b0;
            active_count_q <= '0;
        end else begin
            state_q        <= state_d;
            scan_idx_q     <= scan_idx_d;
            c_on_q         <= c_on_d;
            c_note_q       <= c_note_d;
            c_chan_q       <= c_chan_d;
            c_vel_q        <= c_vel_d;
            best_valid_q   <= best_valid_d;
            best_class_q   <= best_class_d;
            best_age_q     <= best_age_d;
            best_idx_q     <= best_idx_d;
            now_q          <= now_d;
            wr_valid_q     <= wr_valid_d;
            wr_idx_q       <= wr_idx_d;
            wr_kind_q      <= wr_kind_d;
            wr_note_q      <= wr_note_d;
            wr_chan_q      <= wr_chan_d;
            wr_vel_q       <= wr_vel_d;
            miss_q         <= miss_d;
            active_count_q <= active_count_d;
        end
    end

    // Voice shadow table registers
    always_ff @(posedge clk32 or posedge rst) begin
        if (rst) begin
            used_q <= '0;
            rel_q  <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                vnote_q[i]  <= '0;
                vchan_q[i]  <= '0;
                vstamp_q[i] <= '0;
            end
        end else begin
            used_q   <= used_d;
            rel_q    <= rel_d;
            vnote_q  <= vnote_d;
            vchan_q  <= vchan_d;
            vstamp_q <= vstamp_d;
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: table of note commands with expected
// slot decisions, a scoreboard queue, and hand-written reset/abort sequences.
module tb_voice_allocator;
    import synth_pkg::*;

    localparam int NV = 32;
    localparam int VW = 5;
    localparam int SW = 16;

    logic          clk32 = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_on = 1'b0;
    logic [6:0]    cmd_note = '0;
    logic [3:0]    cmd_channel = '0;
    logic [6:0]    cmd_velocity = '0;
    logic          free_valid = 1'b0;
    logic [VW-1:0] free_idx = '0;
    logic          wr_valid;
    logic          wr_ready = 1'b1;
    logic [VW-1:0] wr_idx;
    logic [1:0]    wr_kind;
    logic [6:0]    wr_note;
    logic [3:0]    wr_channel;
    logic [6:0]    wr_velocity;
    logic [VW:0]   active_count;
    logic          busy;
    logic          miss;

    voice_allocator #(.NUM_VOICES(NV), .VIDX_W(VW), .STAMP_W(SW)) dut (
        .clk32(clk32), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_on(cmd_on),
        .cmd_note(cmd_note), .cmd_channel(cmd_channel), .cmd_velocity(cmd_velocity),
        .free_valid(free_valid), .free_idx(free_idx),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_idx(wr_idx), .wr_kind(wr_kind),
        .wr_note(wr_note), .wr_channel(wr_channel), .wr_velocity(wr_velocity),
        .active_count(active_count), .busy(busy), .miss(miss)
    );

    initial forever #5 clk32 = ~clk32;

    typedef struct {
        logic       on;
        logic [6:0] note;
        logic [3:0] ch;
        logic [6:0] vel;
        logic [1:0] kind;
        logic [4:0] idx;
        logic       is_miss;
        int         hold;
        logic       free_hs;
        int         act;
    } vec_t;

    typedef struct {
        logic [1:0] kind;
        logic [4:0] idx;
        logic [6:0] note;
        logic [3:0] ch;
        logic [6:0] vel;
        logic       is_miss;
    } exp_t;

    vec_t tbl[$];
    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic on, input int note, input int ch, input int vel,
                                input logic [1:0] kind, input int idx, input logic m,
                                input int hold, input logic fr, input int act);
        vec_t v;
        v.on = on; v.note = 7'(note); v.ch = 4'(ch); v.vel = 7'(vel);
        v.kind = kind; v.idx = 5'(idx); v.is_miss = m;
        v.hold = hold; v.free_hs = fr; v.act = act;
        return v;
    endfunction

    task automatic apply(input vec_t v, input string tag);
        exp_t e;
        int   cyc;
        bit   seen;
        cyc = 0;
        while (cmd_ready !== 1'b1 && cyc < 200) begin
            @(negedge clk32);
            cyc++;
        end
        chk({tag, " ready"}, 32'(cmd_ready), 32'd1);
        wr_ready     = (v.hold > 0) ? 1'b0 : 1'b1;
        cmd_valid    = 1'b1;
        cmd_on       = v.on;
        cmd_note     = v.note;
        cmd_channel  = v.ch;
        cmd_velocity = v.vel;
        @(posedge clk32);
        #1;
        cmd_valid = 1'b0;
        e.kind = v.kind; e.idx = v.idx; e.note = v.note; e.ch = v.ch; e.vel = v.vel;
        e.is_miss = v.is_miss;
        exp_q.push_back(e);

        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 100) begin
            @(negedge clk32);
            cyc++;
            if (wr_valid === 1'b1 || miss === 1'b1) seen = 1'b1;
        end
        chk({tag, " latency"}, 32'(cyc), 32'(NV + 1));
        e = exp_q.pop_front();

        if (e.is_miss) begin
            chk({tag, " miss"}, 32'(miss), 32'd1);
            chk({tag, " no wr"}, 32'(wr_valid), 32'd0);
            @(negedge clk32);
            chk({tag, " miss pulse"}, 32'(miss), 32'd0);
            chk({tag, " ready after miss"}, 32'(cmd_ready), 32'd1);
            chk({tag, " still no wr"}, 32'(wr_valid), 32'd0);
        end else begin
            chk({tag, " wr_valid"}, 32'(wr_valid), 32'd1);
            chk({tag, " kind"}, 32'(wr_kind), 32'(e.kind));
            chk({tag, " idx"}, 32'(wr_idx), 32'(e.idx));
            chk({tag, " note"}, 32'(wr_note), 32'(e.note));
            chk({tag, " chan"}, 32'(wr_channel), 32'(e.ch));
            chk({tag, " vel"}, 32'(wr_velocity), 32'(e.vel));
            for (int k = 0; k < v.hold; k++) begin
                @(negedge clk32);
                chk({tag, " hold valid"}, 32'(wr_valid), 32'd1);
                chk({tag, " hold idx"}, 32'(wr_idx), 32'(e.idx));
                chk({tag, " hold kind"}, 32'(wr_kind), 32'(e.kind));
                chk({tag, " hold note"}, 32'(wr_note), 32'(e.note));
                chk({tag, " hold busy"}, 32'({busy, cmd_ready}), 32'd2);
            end
            wr_ready   = 1'b1;
            free_valid = v.free_hs;
            free_idx   = e.idx;
            @(posedge clk32);
            #1;
            free_valid = 1'b0;
            @(negedge clk32);
            chk({tag, " ready after hs"}, 32'(cmd_ready), 32'd1);
            chk({tag, " wr dropped"}, 32'(wr_valid), 32'd0);
        end
        if (v.act >= 0) begin
            @(negedge clk32);
            chk({tag, " active_count"}, 32'(active_count), 32'(v.act));
        end
    endtask

    initial begin
        int  cyc;
        bit  seen;

        // Fill 60..91 on channel 0, then the multi-voice corner cases.
        for (int i = 0; i < NV; i++) begin
            tbl.push_back(mk(1'b1, 60 + i, 0, 10 + i, WR_START, i, 1'b0, 0, 1'b0,
                             (i == NV - 1) ? NV : -1));
        end
        tbl.push_back(mk(1'b1, 100, 0, 50, WR_STEAL,   0,  1'b0, 0,  1'b0, 32));
        tbl.push_back(mk(1'b1, 102, 0, 51, WR_STEAL,   1,  1'b0, 0,  1'b0, -1));
        tbl.push_back(mk(1'b0, 75,  0, 52, WR_RELEASE, 15, 1'b0, 0,  1'b0, 32));
        tbl.push_back(mk(1'b1, 101, 0, 53, WR_STEAL,   15, 1'b0, 0,  1'b0, -1));
        tbl.push_back(mk(1'b1, 100, 0, 54, WR_RETRIG,  0,  1'b0, 0,  1'b0, -1));
        tbl.push_back(mk(1'b0, 20,  3, 55, WR_START,   0,  1'b1, 0,  1'b0, -1));
        tbl.push_back(mk(1'b0, 70,  1, 56, WR_START,   0,  1'b1, 0,  1'b0, -1));
        tbl.push_back(mk(1'b1, 103, 0, 57, WR_STEAL,   2,  1'b0, 10, 1'b1, 32));
        tbl.push_back(mk(1'b0, 103, 0, 58, WR_RELEASE, 2,  1'b0, 3,  1'b1, 31));
        tbl.push_back(mk(1'b1, 104, 0, 59, WR_START,   2,  1'b0, 0,  1'b0, 32));

        @(negedge clk32);
        chk("rst cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst wr_valid", 32'(wr_valid), 32'd0);
        chk("rst wr fields", 32'({wr_idx, wr_kind, wr_note, wr_channel, wr_velocity}), 32'd0);
        chk("rst active", 32'(active_count), 32'd0);
        chk("rst busy/miss", 32'({busy, miss}), 32'd0);
        rst = 1'b0;
        #1;
        chk("post-rst cmd_ready", 32'(cmd_ready), 32'd1);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("v%0d", i));
        end

        // Abort a command with an asynchronous reset partway through the scan.
        cyc = 0;
        while (cmd_ready !== 1'b1 && cyc < 200) begin
            @(negedge clk32);
            cyc++;
        end
        cmd_valid = 1'b1; cmd_on = 1'b1; cmd_note = 7'd50; cmd_channel = 4'd2; cmd_velocity = 7'd9;
        @(posedge clk32);
        #1;
        cmd_valid = 1'b0;
        repeat (10) @(negedge clk32);
        chk("abort busy before rst", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort wr_valid", 32'(wr_valid), 32'd0);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort active", 32'(active_count), 32'd0);
        chk("abort cmd_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk32);
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 45; k++) begin
            @(negedge clk32);
            if (wr_valid === 1'b1) seen = 1'b1;
        end
        chk("abort no wr", 32'(seen), 32'd0);
        chk("abort idle", 32'({busy, cmd_ready}), 32'd1);
        apply(mk(1'b1, 60, 0, 33, WR_START,  0, 1'b0, 0, 1'b0, 1), "fresh");
        apply(mk(1'b1, 60, 0, 34, WR_RETRIG, 0, 1'b0, 0, 1'b0, 1), "retrig60");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
